// File: rtl/can_crc15_rx.sv
// can_crc15_rx: receive-side CAN CRC-15 engine; define CAN_CRC_DELIM_CHECK_EN to add the CRC delimiter check
module can_crc15_rx #(
  parameter logic [14:0] POLY     = 15'h4599,
  parameter int          CRC_BITS = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        sof,
  input  logic        last_data_bit,
  output logic [14:0] calculated_crc,
  output logic [14:0] received_crc,
  output logic        check_enable,
  output logic        busy,
  output logic        delim_error
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
`ifdef CAN_CRC_DELIM_CHECK_EN
    RECV,
    DELIM
`else
    RECV
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] calc_q, calc_d;
  logic [14:0] recv_q, recv_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ce_q, ce_d;
`ifdef CAN_CRC_DELIM_CHECK_EN
  logic        de_q, de_d;
`endif

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? POLY : 15'h0);
  endfunction

  // next-state: enable-low clear, SOF restart (wins over everything), then per-state bit consumption
  always_comb begin
    state_d = state_q;
    calc_d  = calc_q;
    recv_d  = recv_q;
    cnt_d   = cnt_q;
    ce_d    = 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
    de_d    = 1'b0;
`endif
    if (!enable) begin
      state_d = IDLE;
      calc_d  = '0;
      recv_d  = '0;
      cnt_d   = '0;
    end else if (bit_valid && sof) begin
      recv_d  = '0;
      cnt_d   = '0;
      calc_d  = crc_step(15'h0, bit_in);
      state_d = last_data_bit ? RECV : CALC;
    end else if (bit_valid) begin
      case (state_q)
        CALC: begin
          calc_d = crc_step(calc_q, bit_in);
          if (last_data_bit) begin
            state_d = RECV;
            cnt_d   = '0;
          end
        end
        RECV: begin
          recv_d = {recv_q[13:0], bit_in};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'(CRC_BITS - 1)) begin
            ce_d = 1'b1;
`ifdef CAN_CRC_DELIM_CHECK_EN
            state_d = DELIM;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef CAN_CRC_DELIM_CHECK_EN
        DELIM: begin
          de_d    = ~bit_in;
          state_d = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      calc_q  <= '0;
      recv_q  <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
`ifdef CAN_CRC_DELIM_CHECK_EN
      de_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      calc_q  <= calc_d;
      recv_q  <= recv_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
`ifdef CAN_CRC_DELIM_CHECK_EN
      de_q    <= de_d;
`endif
    end
  end

  assign calculated_crc = calc_q;
  assign received_crc   = recv_q;
  assign check_enable   = ce_q;
  assign busy           = state_q != IDLE;
`ifdef CAN_CRC_DELIM_CHECK_EN
  assign delim_error    = de_q;
`else
  assign delim_error    = 1'b0;
`endif
endmodule

// File: tb/tb_can_crc15_rx.sv
// tb_can_crc15_rx: random and directed frames checked against a queue/long-division model of the CRC-15 receiver
module tb_can_crc15_rx;
`ifdef CAN_CRC_DELIM_CHECK_EN
  localparam bit DEL = 1'b1;
`else
  localparam bit DEL = 1'b0;
`endif

  logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic bit_valid = 1'b0, bit_in = 1'b0, sof = 1'b0, last_data_bit = 1'b0;
  logic [14:0] calculated_crc, received_crc;
  logic check_enable, busy, delim_error;

  int errors = 0, checks = 0, ce_cnt = 0, de_cnt = 0;

  bit          dq[$];
  int          mode = 0, k = 0;
  logic [14:0] e_calc = '0, e_recv = '0;
  logic        e_ce = 1'b0, e_de = 1'b0;

  can_crc15_rx dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .bit_valid(bit_valid),
    .bit_in(bit_in), .sof(sof), .last_data_bit(last_data_bit),
    .calculated_crc(calculated_crc), .received_crc(received_crc),
    .check_enable(check_enable), .busy(busy), .delim_error(delim_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [14:0] a, input logic [14:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [14:0] crc_of();
    logic [15:0] r = '0;
    for (int i = 0; i < dq.size() + 15; i++) begin
      r = {r[14:0], (i < dq.size()) ? dq[i] : 1'b0};
      if (r[15]) r ^= 16'hC599;
    end
    return r[14:0];
  endfunction

  task automatic model_reset();
    mode = 0; k = 0; dq.delete();
    e_calc = '0; e_recv = '0; e_ce = 1'b0; e_de = 1'b0;
  endtask

  task automatic model_update(input logic e, input logic v, input logic b, input logic s, input logic l);
    e_ce = 1'b0;
    e_de = 1'b0;
    if (!e) begin
      mode = 0; k = 0; dq.delete(); e_recv = '0;
    end else if (v && s) begin
      dq.delete(); dq.push_back(b); e_recv = '0; k = 0;
      mode = l ? 2 : 1;
    end else if (v) begin
      if (mode == 1) begin
        dq.push_back(b);
        if (l) begin mode = 2; k = 0; end
      end else if (mode == 2) begin
        e_recv = {e_recv[13:0], b};
        k++;
        if (k == 15) begin e_ce = 1'b1; mode = DEL ? 3 : 0; end
      end else if (mode == 3) begin
        e_de = ~b;
        mode = 0;
      end
    end
    e_calc = crc_of();
  endtask

  always @(negedge clock) begin
    chk("calculated_crc", calculated_crc, e_calc);
    chk("received_crc", received_crc, e_recv);
    chk("check_enable", 15'(check_enable), 15'(e_ce));
    chk("busy", 15'(busy), 15'(mode != 0));
    chk("delim_error", 15'(delim_error), 15'(e_de));
    if (check_enable) ce_cnt++;
    if (delim_error) de_cnt++;
  end

  task automatic step(input logic e, input logic v, input logic b, input logic s, input logic l);
    @(negedge clock);
    enable = e; bit_valid = v; bit_in = b; sof = s; last_data_bit = l;
    @(posedge clock);
    model_update(e, v, b, s, l);
  endtask

  task automatic send(input logic b, input logic s, input logic l);
    step(1'b1, 1'b1, b, s, l);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [31:0] data, input int n, input logic [14:0] crc, input logic d);
    send(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) send(data[n-1-i], 1'b0, i == n - 1);
    for (int i = 0; i < 15; i++) send(crc[14-i], 1'b0, 1'b0);
    send(d, 1'b0, 1'b0);
  endtask

  task automatic rnd(input logic b, input logic l);
    if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    if ($urandom_range(0, 59) == 0) step(1'b0, 1'b1, b, 1'b0, l);
    else if ($urandom_range(0, 49) == 0) send(b, 1'b1, l);
    else send(b, 1'b0, l);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) idle();
    chk("idle_busy", 15'(busy), 15'h0);
    chk("idle_calc", calculated_crc, 15'h0);

    ce_cnt = 0; de_cnt = 0;
    frame(32'h1, 1, 15'h4599, 1'b1);
    idle(); idle();
    chk("single1_calc", calculated_crc, 15'h4599);
    chk("single1_recv", received_crc, 15'h4599);
    chk("single1_ce_pulses", 15'(ce_cnt), 15'd1);
    chk("single1_de_pulses", 15'(de_cnt), 15'd0);

    de_cnt = 0;
    frame(32'h1, 1, 15'h4599, 1'b0);
    idle(); idle();
    chk("delim0_pulses", 15'(de_cnt), 15'(DEL));

    ce_cnt = 0;
    frame(32'h3, 2, 15'h0, 1'b1);
    idle(); idle();
    chk("two_ones_calc", calculated_crc, 15'h0B32);
    chk("two_ones_recv", received_crc, 15'h0000);
    chk("two_ones_ce_pulses", 15'(ce_cnt), 15'd1);

    ce_cnt = 0;
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send(1'($urandom), 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    #1;
    chk("abort_recv", received_crc, 15'h0);
    chk("abort_calc", calculated_crc, 15'h4599);
    chk("abort_ce_pulses", 15'(ce_cnt), 15'd0);
    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) send(1'($urandom), 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    idle(); idle();
    chk("abort_new_ce_pulses", 15'(ce_cnt), 15'd1);

    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("enlow_calc", calculated_crc, 15'h0);
    chk("enlow_recv", received_crc, 15'h0);
    chk("enlow_busy", 15'(busy), 15'h0);
    idle();

    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 20);
      send(1'($urandom), 1'b1, $urandom_range(0, 15) == 0);
      for (int i = 0; i < n; i++) rnd(1'($urandom), i == n - 1);
      for (int i = 0; i < 15; i++) rnd(1'($urandom), $urandom_range(0, 9) == 0);
      rnd($urandom_range(0, 3) != 0, 1'b0);
      repeat ($urandom_range(0, 3)) step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    end

    ce_cnt = 0;
    send(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send(1'($urandom), 1'b0, i == 4);
    for (int i = 0; i < 6; i++) send(1'($urandom), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    bit_valid = 1'b0; sof = 1'b0; last_data_bit = 1'b0;
    model_reset();
    #1;
    chk("areset_calc", calculated_crc, 15'h0);
    chk("areset_recv", received_crc, 15'h0);
    chk("areset_busy", 15'(busy), 15'h0);
    chk("areset_ce", 15'(check_enable), 15'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) idle();
    chk("areset_ce_pulses", 15'(ce_cnt), 15'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/can_crc15_rx.md
# can_crc15_rx

Receive-side CRC-15 engine for the CAN controller. It sits between the bit destuffer and the CRC checker. It runs the CAN CRC-15 polynomial over destuffed frame bits from SOF through the last data bit, then shifts in the 15 transmitted CRC bits. It presents `calculated_crc`, `received_crc` and a one-cycle `check_enable` strobe to the downstream checker, and optionally checks the CRC delimiter.

## Interface
- `POLY`, 15'h4599, CRC-15 generator polynomial (x^15 term implicit).
- `CRC_BITS`, 15, number of CRC bits captured; fixed by the CAN standard and not intended to be overridden.
- `clock`  input  1  system clock, all logic on rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `enable`  input  1  block enable; low forces a synchronous return to IDLE and clears all outputs.
- `bit_valid`  input  1  one-cycle strobe; `bit_in` is a valid destuffed bit.
- `bit_in`  input  1  destuffed bit value (0 = dominant).
- `sof`  input  1  qualifies the current `bit_valid` as the SOF bit.
- `last_data_bit`  input  1  qualifies the current `bit_valid` as the final CRC-covered bit.
- `calculated_crc`  output  15  running/final CRC register.
- `received_crc`  output  15  CRC field shifted in MSB first.
- `check_enable`  output  1  one-cycle strobe; both CRC values are final and stable.
- `busy`  output  1  high in any state other than IDLE.
- `delim_error`  output  1  one-cycle pulse; CRC delimiter sampled dominant.

## Operation
- Reset state: IDLE.
- Reset values: `calculated_crc`=0, `received_crc`=0, `check_enable`=0, `busy`=0, `delim_error`=0.
- CRC step, applied once per consumed bit:
  - nxt = `bit_in` ^ crc[14];
  - crc = {crc[13:0],1'b0};
  - if nxt, crc ^= `POLY`.
  - All arithmetic is 15-bit; the shifted-out bit is discarded.
- States: IDLE, CALC, RECV, DELIM (DELIM exists only with the macro enabled).
- IDLE:
  - On `bit_valid & sof`: clear `received_crc`, apply one CRC step starting from crc=0, go to CALC.
  - `bit_valid` without `sof` is ignored.
- CALC:
  - On each `bit_valid`: apply a CRC step.
  - If `last_data_bit` is also high: go to RECV and clear the bit counter (4-bit).
- RECV:
  - On each `bit_valid`: `received_crc` <= {received_crc[13:0], bit_in} and the counter increments.
  - On the 15th bit (counter==14): set `check_enable`, go to DELIM (or IDLE without the macro).
- DELIM:
  - On the next `bit_valid`: `delim_error` <= ~`bit_in`, go to IDLE.
- `calculated_crc` and `received_crc` hold their values after the frame until the next SOF.
- `sof & bit_valid` in CALC, RECV or DELIM aborts the current frame:
  - restart as from IDLE with this bit;
  - no `check_enable` is produced for the aborted frame.
- `sof` together with `last_data_bit` on the same strobe: `sof` handling wins, then `last_data_bit` is applied, and the block goes directly to RECV.
- `last_data_bit` outside CALC is ignored.
- `sof` or `last_data_bit` without `bit_valid` is ignored.
- `enable` low: next edge goes to IDLE, clears both CRC registers and the counter, and drops all strobes.
- Async reset mid-frame: immediate return to reset values; the frame is lost.

## Timing
- CRC update latency: 1 cycle. `calculated_crc` reflects a bit on the edge that consumes its `bit_valid`.
- `check_enable`:
  - high exactly 1 cycle, in the cycle after the edge that consumed the 15th CRC bit;
  - `received_crc` is already final in that cycle.
- `delim_error`: high 1 cycle, after the edge consuming the delimiter bit.
- `busy` rises the cycle after the SOF strobe and falls the cycle after the final consumed bit.
- `bit_valid` may be asserted on back-to-back cycles; one bit per cycle is sustained, with no stall.

## Configuration
- Macro: `CAN_CRC_DELIM_CHECK_EN`.
- Defined:
  - DELIM state present;
  - delimiter sampled;
  - `delim_error` driven;
  - `busy` covers the delimiter bit.
- Undefined:
  - RECV returns to IDLE after the 15th CRC bit;
  - `delim_error` tied to 0;
  - the delimiter bit is ignored as an IDLE non-SOF bit.

## Test plan
- Reset release, no stimulus -> all outputs 0, `busy`=0 indefinitely.
- Single-1 frame:
  - Stimulus: SOF bit 0, data bit 1 with `last_data_bit`, CRC bits 100010110011001, delimiter 1.
  - Response: `calculated_crc`=15'h4599, `received_crc`=15'h4599, one `check_enable` pulse, `delim_error`=0.
- Same frame with delimiter 0 -> `delim_error` pulses once. With the macro undefined -> `delim_error` stays 0.
- Two data bits 1,1 (after SOF 0), then 15 zero CRC bits -> `calculated_crc`=15'h0B32, `received_crc`=15'h0000, `check_enable` pulses once.
- Abort and enable-low cases:
  - `sof` asserted during RECV bit 7 -> no `check_enable` for the aborted frame, `received_crc` cleared, new CRC restarted.
  - `enable` low mid-frame -> IDLE and zeros on the next edge.
- Back-to-back `bit_valid` for a whole frame, then `reset_n` dropped mid-CRC field -> outputs 0 immediately (asynchronous), no `check_enable`.
